// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and last-word padding helper for the SHA-256 message padder.
package sha256_pkg;

    localparam int BLOCK_W = 512;
    localparam int WORD_W  = 32;
    localparam int LEN_W   = 64;
    localparam int WORDS   = 16;

    localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_PAD   = 3'd2,
        S_LEN   = 3'd3,
        S_ISSUE = 3'd4,
        S_WAIT0 = 3'd5,
        S_WAIT  = 3'd6
    } state_t;

    // Keep the k leading bytes, put the 0x80 marker in byte k (k<4), zero the rest.
    function automatic logic [WORD_W-1:0] pad_last(input logic [WORD_W-1:0] d,
                                                   input logic [2:0] k);
        logic [WORD_W-1:0] r;
        case (k)
            3'd0:    r = PAD_WORD;
            3'd1:    r = {d[31:24], 8'h80, 16'h0000};
            3'd2:    r = {d[31:16], 8'h80, 8'h00};
            3'd3:    r = {d[31:8], 8'h80};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// 16x32 block register file: indexed word write, length write into words 14/15, and clear.
module sha256_block_buf
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [3:0]         wr_idx,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic               len_we,
    input  logic [LEN_W-1:0]   len_val,
    output logic [BLOCK_W-1:0] block
);

    logic [WORD_W-1:0] mem [WORDS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else begin
            if (wr_en) mem[wr_idx] <= wr_data;
            if (len_we) begin
                mem[14] <= len_val[63:32];
                mem[15] <= len_val[31:0];
            end
        end
    end

    // Word 0 occupies the most significant 32 bits of the block.
    always_comb begin
        block = '0;
        for (int i = 0; i < WORDS; i++) block[BLOCK_W-1-WORD_W*i -: WORD_W] = mem[i];
    end

endmodule

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs 32-bit words into 512-bit blocks and sequences sha256_core.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter bit MODE = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    input  logic [2:0]         in_bytes,
    output logic               core_init,
    output logic               core_next,
    output logic               core_mode,
    output logic [BLOCK_W-1:0] core_block,
    input  logic               core_ready,
    output logic               busy,
    output logic               msg_done,
    output logic [2:0]         dbg_state
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready; the
    // source must hold in_data/in_last/in_bytes stable while in_valid is high and in_ready low.

    state_t            state, state_d;
    logic [3:0]        widx, widx_d;
    logic [LEN_W-1:0]  len, len_d;
    logic              first, first_d;
    logic              pad_pending, pad_d;
    logic              tail, tail_d;
    logic              final_blk, final_d;
    logic              live;

    logic              buf_clr, buf_we, buf_len_we;
    logic [WORD_W-1:0] buf_data;
    logic              accept;
    logic [2:0]        k;

    assign accept    = in_valid && in_ready;
    assign k         = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign core_mode = MODE;

    sha256_block_buf u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (buf_clr),
        .wr_en   (buf_we),
        .wr_idx  (widx),
        .wr_data (buf_data),
        .len_we  (buf_len_we),
        .len_val (len),
        .block   (core_block)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            widx        <= '0;
            len         <= '0;
            first       <= 1'b1;
            pad_pending <= 1'b0;
            tail        <= 1'b0;
            final_blk   <= 1'b0;
            live        <= 1'b0;
        end else begin
            state       <= state_d;
            widx        <= widx_d;
            len         <= len_d;
            first       <= first_d;
            pad_pending <= pad_d;
            tail        <= tail_d;
            final_blk   <= final_d;
            live        <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state;
        widx_d     = widx;
        len_d      = len;
        first_d    = first;
        pad_d      = pad_pending;
        tail_d     = tail;
        final_d    = final_blk;
        buf_clr    = 1'b0;
        buf_we     = 1'b0;
        buf_len_we = 1'b0;
        buf_data   = in_data;
        case (state)
            S_IDLE, S_FILL: begin
                if (accept) begin
                    buf_we = 1'b1;
                    widx_d = widx + 4'd1;
                    if (!in_last) begin
                        len_d   = len + 64'd32;
                        state_d = (widx == 4'd15) ? S_ISSUE : S_FILL;
                    end else begin
                        buf_data = pad_last(in_data, k);
                        len_d    = len + {58'd0, k, 3'b000};
                        pad_d    = (k == 3'd4);
                        tail_d   = 1'b1;
                        state_d  = (widx == 4'd15) ? S_ISSUE : S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (widx == 4'd14 && !pad_pending) begin
                    state_d = S_LEN;
                end else begin
                    buf_we   = 1'b1;
                    buf_data = pad_pending ? PAD_WORD : '0;
                    pad_d    = 1'b0;
                    widx_d   = widx + 4'd1;
                    if (widx == 4'd15) state_d = S_ISSUE;
                end
            end
            S_LEN: begin
                buf_len_we = 1'b1;
                final_d    = 1'b1;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                first_d = 1'b0;
                state_d = S_WAIT0;
            end
            S_WAIT0: state_d = S_WAIT;
            S_WAIT: begin
                if (core_ready) begin
                    buf_clr = 1'b1;
                    widx_d  = '0;
                    if (final_blk) begin
                        state_d = S_IDLE;
                        len_d   = '0;
                        first_d = 1'b1;
                        pad_d   = 1'b0;
                        tail_d  = 1'b0;
                        final_d = 1'b0;
                    end else begin
                        state_d = tail ? S_PAD : S_FILL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = live && (state == S_IDLE || state == S_FILL);
        core_init = (state == S_ISSUE) && first;
        core_next = (state == S_ISSUE) && !first;
        busy      = (state != S_IDLE);
        msg_done  = (state == S_WAIT) && final_blk && core_ready;
        dbg_state = state;
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder with a behavioural core-ready model and a block scoreboard.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [31:0]  in_data = '0;
    logic [2:0]   in_bytes = '0;
    logic         core_ready = 1'b1;
    logic         in_ready, core_init, core_next, core_mode, busy, msg_done;
    logic [511:0] core_block;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int done_cnt = 0;
    int core_lat = 5;
    int core_cnt = 0;

    logic [512:0] exp_q[$];
    logic [31:0]  bw[16];
    logic [511:0] hold_blk;

    sha256_padder #(.MODE(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .core_init  (core_init),
        .core_next  (core_next),
        .core_mode  (core_mode),
        .core_block (core_block),
        .core_ready (core_ready),
        .busy       (busy),
        .msg_done   (msg_done),
        .dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pack_bw();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = bw[i];
        return r;
    endfunction

    function automatic logic [31:0] w56(input int i);
        logic [7:0] b;
        b = 8'(8'h61 + i);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    task automatic clear_bw();
        for (int i = 0; i < 16; i++) bw[i] = '0;
    endtask

    // Core model: drops ready on a start pulse, raises it core_lat cycles later.
    always @(posedge clk) begin
        #1;
        if (core_init || core_next) begin
            core_ready = 1'b0;
            core_cnt   = core_lat;
        end else if (core_cnt > 0) begin
            core_cnt = core_cnt - 1;
            if (core_cnt == 0) core_ready = 1'b1;
        end
    end

    // Scoreboard: every start pulse must match the head of exp_q (bit 512 = init).
    always @(negedge clk) begin
        logic [512:0] e;
        if (core_init || core_next) begin
            pulse_cnt++;
            check("pulse_expected", 512'(exp_q.size() > 0), 512'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pulse_kind", 512'({core_init, core_next}), 512'(e[512] ? 2'b10 : 2'b01));
                check("block", core_block, e[511:0]);
            end
        end
        if (msg_done) begin
            done_cnt++;
            check("done_with_ready", 512'(core_ready), 512'(1));
        end
    end

    task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("in_ready_timeout", 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int t = 0;
        while (done_cnt == start && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("done_once", 512'(done_cnt - start), 512'(1));
        check("idle_after_done", 512'({busy, in_ready}), 512'(2'b01));
        check("queue_empty", 512'(exp_q.size()), 512'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 512'(in_ready), 512'(0));
        check({tag, "_pulses"}, 512'({core_init, core_next}), 512'(0));
        check({tag, "_block"}, core_block, 512'(0));
        check({tag, "_busy"}, 512'(busy), 512'(0));
        check({tag, "_msg_done"}, 512'(msg_done), 512'(0));
        check({tag, "_state"}, 512'(dbg_state), 512'(0));
    endtask

    initial begin
        int p0;
        // reset
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("core_mode", 512'(core_mode), 512'(1));
        reset_n = 1'b1;
        #1;
        check("in_ready_before_edge", 512'(in_ready), 512'(0));
        @(negedge clk);
        check("in_ready_after_release", 512'(in_ready), 512'(1));

        // "abc"
        clear_bw();
        bw[0] = 32'h61626380;
        bw[15] = 32'h00000018;
        exp_q.push_back({1'b1, pack_bw()});
        send(32'h61626300, 1'b1, 3'd3);
        wait_done();

        // empty message: data bytes must be discarded
        clear_bw();
        bw[0] = 32'h80000000;
        exp_q.push_back({1'b1, pack_bw()});
        send(32'hDEADBEEF, 1'b1, 3'd0);
        wait_done();

        // 56-byte message: marker fits, length spills into a second block
        clear_bw();
        for (int i = 0; i < 14; i++) bw[i] = w56(i);
        bw[14] = 32'h80000000;
        exp_q.push_back({1'b1, pack_bw()});
        clear_bw();
        bw[15] = 32'h000001C0;
        exp_q.push_back({1'b0, pack_bw()});
        for (int i = 0; i < 14; i++) send(w56(i), (i == 13), 3'd4);
        wait_done();

        // 64-byte message ending on a full word
        clear_bw();
        for (int i = 0; i < 16; i++) bw[i] = 32'hA5000000 | 32'(i);
        exp_q.push_back({1'b1, pack_bw()});
        clear_bw();
        bw[0] = 32'h80000000;
        bw[15] = 32'h00000200;
        exp_q.push_back({1'b0, pack_bw()});
        for (int i = 0; i < 16; i++) send(32'hA5000000 | 32'(i), (i == 15), 3'd4);
        wait_done();

        // slow core with source stalled on in_valid
        core_lat = 25;
        clear_bw();
        for (int i = 0; i < 16; i++) bw[i] = 32'hC0DE0000 | 32'(i);
        hold_blk = pack_bw();
        exp_q.push_back({1'b1, hold_blk});
        clear_bw();
        bw[0] = 32'hAABB8000;
        bw[15] = 32'h00000210;
        exp_q.push_back({1'b0, pack_bw()});
        for (int i = 0; i < 16; i++) send(32'hC0DE0000 | 32'(i), 1'b0, 3'd4);
        in_valid = 1'b1;
        in_data  = 32'hAABBCCDD;
        in_last  = 1'b1;
        in_bytes = 3'd2;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_in_ready", 512'(in_ready), 512'(0));
            check("hold_no_pulse", 512'({core_init, core_next}), 512'(0));
            check("hold_block", core_block, hold_blk);
        end
        core_lat = 5;
        send(32'hAABBCCDD, 1'b1, 3'd2);
        wait_done();

        // reset mid-message
        p0 = pulse_cnt;
        for (int i = 0; i < 7; i++) send(32'h11110000 | 32'(i), 1'b0, 3'd4);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        check("midreset_no_pulse", 512'(pulse_cnt - p0), 512'(0));
        reset_n = 1'b1;
        clear_bw();
        bw[0] = 32'h61626380;
        bw[15] = 32'h00000018;
        exp_q.push_back({1'b1, pack_bw()});
        send(32'h61626300, 1'b1, 3'd3);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
